// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the instruction-memory read port and the IF/ID
// pipeline-register outputs of the fetch stage into one bundle.
//
//   im_addr_o      fetch -> IM      read address (current PC)
//   im_rd_en_o     fetch -> IM      read enable
//   im_instr_i     IM    -> fetch   instruction at im_addr_o, same cycle
//   ifid_instr_o   fetch -> decode  IF/ID instruction
//   ifid_pc_o      fetch -> decode  PC of ifid_instr_o
//   ifid_pc_inc_o  fetch -> decode  ifid_pc_o + 1 (modulo)
//   ifid_valid_o   fetch -> decode  IF/ID holds a real instruction
//
// master: the fetch stage.  slave: the IM / decode side.
interface fetch_stage_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  im_addr_o;
  logic               im_rd_en_o;
  logic [INSTR_W-1:0] im_instr_i;
  logic [INSTR_W-1:0] ifid_instr_o;
  logic [ADDR_W-1:0]  ifid_pc_o;
  logic [ADDR_W-1:0]  ifid_pc_inc_o;
  logic               ifid_valid_o;

  modport master (
    output im_addr_o, im_rd_en_o,
    input  im_instr_i,
    output ifid_instr_o, ifid_pc_o, ifid_pc_inc_o, ifid_valid_o
  );

  modport slave (
    input  im_addr_o, im_rd_en_o,
    output im_instr_i,
    input  ifid_instr_o, ifid_pc_o, ifid_pc_inc_o, ifid_valid_o
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, drives the instruction
// memory and loads the IF/ID register. Handles stall, branch redirect with
// wrong-path flush, and halt detection with a pipeline drain before hlt_o.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   stall_i      hold PC and IF/ID
//   br_taken_i   branch/jump resolved taken this cycle
//   br_target_i  redirect address (valid with br_taken_i)
//   bus          fetch_stage_if.master: IM read port + IF/ID outputs
//   hlt_o        sticky halt, cleared only by reset
module fetch_stage #(
  parameter int                 ADDR_W    = 16,
  parameter int                 INSTR_W   = 16,
  parameter int                 OPC_W     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [OPC_W-1:0]   HLT_OPC   = 4'hF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int                 DRAIN     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  fetch_stage_if.master     bus,
  output logic              hlt_o
);

  localparam int CNT_W = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;
  logic [ADDR_W-1:0]  ifid_pc_reg, ifid_pc_next;
  logic [ADDR_W-1:0]  ifid_pc_inc_reg, ifid_pc_inc_next;
  logic               ifid_valid_reg, ifid_valid_next;
  logic               hlt_reg, hlt_next;

  logic [ADDR_W-1:0]  pc_plus1;
  logic [OPC_W-1:0]   opcode;

  // Modulo increment: all-ones wraps to zero.
  assign pc_plus1 = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign opcode   = bus.im_instr_i[INSTR_W-1 -: OPC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_RUN;
      pc_reg          <= RESET_PC;
      cnt_reg         <= '0;
      ifid_instr_reg  <= NOP_INSTR;
      ifid_pc_reg     <= '0;
      ifid_pc_inc_reg <= '0;
      ifid_valid_reg  <= 1'b0;
      hlt_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      cnt_reg         <= cnt_next;
      ifid_instr_reg  <= ifid_instr_next;
      ifid_pc_reg     <= ifid_pc_next;
      ifid_pc_inc_reg <= ifid_pc_inc_next;
      ifid_valid_reg  <= ifid_valid_next;
      hlt_reg         <= hlt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    cnt_next         = cnt_reg;
    ifid_instr_next  = ifid_instr_reg;
    ifid_pc_next     = ifid_pc_reg;
    ifid_pc_inc_next = ifid_pc_inc_reg;
    ifid_valid_next  = ifid_valid_reg;
    hlt_next         = hlt_reg;

    case (state_reg)
      ST_RUN: begin
        if (br_taken_i) begin
          // Redirect wins over a simultaneous stall; the fetched word is wrong-path.
          pc_next         = br_target_i;
          ifid_instr_next = NOP_INSTR;
          ifid_valid_next = 1'b0;
        end else if (!stall_i) begin
          ifid_instr_next  = bus.im_instr_i;
          ifid_pc_next     = pc_reg;
          ifid_pc_inc_next = pc_plus1;
          ifid_valid_next  = 1'b1;
          if (opcode == HLT_OPC) begin
            // PC parks on the halt so a later redirect-free drain stays put.
            cnt_next   = '0;
            state_next = ST_HALT_PEND;
          end else begin
            pc_next = pc_plus1;
          end
        end
      end

      ST_HALT_PEND: begin
        if (br_taken_i) begin
          // An older branch resolved: the captured halt was on the wrong path.
          pc_next         = br_target_i;
          ifid_instr_next = NOP_INSTR;
          ifid_valid_next = 1'b0;
          state_next      = ST_RUN;
        end else if (!stall_i) begin
          ifid_instr_next = NOP_INSTR;
          ifid_valid_next = 1'b0;
          if (cnt_reg == CNT_W'(DRAIN)) begin
            hlt_next   = 1'b1;
            state_next = ST_HALTED;
          end else begin
            cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end

      ST_HALTED: begin
        // Frozen until reset.
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign bus.im_addr_o     = pc_reg;
  assign bus.im_rd_en_o    = (state_reg == ST_RUN) && !stall_i;
  assign bus.ifid_instr_o  = ifid_instr_reg;
  assign bus.ifid_pc_o     = ifid_pc_reg;
  assign bus.ifid_pc_inc_o = ifid_pc_inc_reg;
  assign bus.ifid_valid_o  = ifid_valid_reg;
  assign hlt_o             = hlt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. Stimulus tasks advance a
// behavioural fetch model and queue the expected post-edge outputs; a
// monitor pops and compares after every rising edge. A second instance with
// RESET_PC=16'hFFFE covers PC wrap.
module tb_fetch_stage;

  localparam int DRAIN = 3;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        br_taken_i;
  logic [15:0] br_target_i;
  logic        hlt_o;
  logic        hlt2_o;

  logic [15:0] mem [256];

  fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) u_if ();
  fetch_stage_if #(.ADDR_W(16), .INSTR_W(16)) u_if2 ();

  assign u_if.im_instr_i  = mem[u_if.im_addr_o[7:0]];
  assign u_if2.im_instr_i = {8'h20, u_if2.im_addr_o[7:0]};

  fetch_stage #(.DRAIN(DRAIN)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .bus         (u_if),
    .hlt_o       (hlt_o)
  );

  fetch_stage #(.DRAIN(DRAIN), .RESET_PC(16'hFFFE)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_i     (1'b0),
    .br_taken_i  (1'b0),
    .br_target_i (16'h0000),
    .bus         (u_if2),
    .hlt_o       (hlt2_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int txn   = 0;

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] inc;
    logic        valid;
    logic        hlt;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model: mode 0 = fetching, 1 = draining after halt, 2 = halted.
  logic [15:0] m_pc, m_instr, m_ifpc, m_ifinc;
  logic        m_valid, m_hlt;
  int          m_mode;
  int          m_edges;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ifpc = 16'h0000; m_ifinc = 16'h0000;
    m_valid = 1'b0; m_hlt = 1'b0; m_mode = 0; m_edges = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock: drive inputs, step model, queue expectation, return after edge.
  task automatic cycle(input logic s, input logic b, input logic [15:0] t);
    logic [15:0] ins;
    exp_t e;
    stall_i = s; br_taken_i = b; br_target_i = t;
    ins = mem[m_pc[7:0]];
    case (m_mode)
      0: begin
        if (b) begin
          m_pc = t; m_instr = 16'h0000; m_valid = 1'b0;
        end else if (!s) begin
          m_instr = ins; m_ifpc = m_pc; m_ifinc = m_pc + 16'd1; m_valid = 1'b1;
          if (ins[15:12] == 4'hF) begin
            m_mode = 1; m_edges = 0;
          end else begin
            m_pc = m_pc + 16'd1;
          end
        end
      end
      1: begin
        if (b) begin
          m_pc = t; m_instr = 16'h0000; m_valid = 1'b0; m_mode = 0;
        end else if (!s) begin
          m_instr = 16'h0000; m_valid = 1'b0;
          m_edges++;
          if (m_edges == DRAIN + 1) begin
            m_hlt = 1'b1; m_mode = 2;
          end
        end
      end
      default: ;
    endcase
    e.addr = m_pc; e.rd = (m_mode == 0) && !s; e.instr = m_instr;
    e.pc = m_ifpc; e.inc = m_ifinc; e.valid = m_valid; e.hlt = m_hlt;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 16'h0000;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT against the queued expectation after each edge.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        ok = (u_if.im_addr_o === e.addr) && (u_if.im_rd_en_o === e.rd) &&
             (u_if.ifid_instr_o === e.instr) && (u_if.ifid_valid_o === e.valid) &&
             (hlt_o === e.hlt) &&
             (!e.valid || ((u_if.ifid_pc_o === e.pc) && (u_if.ifid_pc_inc_o === e.inc)));
        tests++;
        if (!ok) begin
          fails++;
          $display("[TB] FAIL txn %0d: got addr=%h rd=%b instr=%h pc=%h inc=%h v=%b hlt=%b, expected addr=%h rd=%b instr=%h pc=%h inc=%h v=%b hlt=%b",
                   txn, u_if.im_addr_o, u_if.im_rd_en_o, u_if.ifid_instr_o, u_if.ifid_pc_o,
                   u_if.ifid_pc_inc_o, u_if.ifid_valid_o, hlt_o,
                   e.addr, e.rd, e.instr, e.pc, e.inc, e.valid, e.hlt);
        end else begin
          $display("[TB] txn %0d ok addr=%h rd=%b instr=%h pc=%h v=%b hlt=%b",
                   txn, u_if.im_addr_o, u_if.im_rd_en_o, u_if.ifid_instr_o,
                   u_if.ifid_pc_o, u_if.ifid_valid_o, hlt_o);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    rst_n = 1'b0; stall_i = 1'b0; br_taken_i = 1'b0; br_target_i = 16'h0000;
    model_reset();
    @(posedge clk); @(posedge clk); #2;
    chk("rst_im_addr",  32'(u_if.im_addr_o),     32'h0000);
    chk("rst_instr",    32'(u_if.ifid_instr_o),  32'h0000);
    chk("rst_pc",       32'(u_if.ifid_pc_o),     32'h0000);
    chk("rst_pc_inc",   32'(u_if.ifid_pc_inc_o), 32'h0000);
    chk("rst_valid",    32'(u_if.ifid_valid_o),  32'h0);
    chk("rst_hlt",      32'(hlt_o),              32'h0);
    chk("rst2_im_addr", 32'(u_if2.im_addr_o),    32'hFFFE);
    rst_n = 1'b1;

    // Sequential fetch; second instance shows PC wrap from FFFE.
    cycle(0, 0, 0);
    chk("wrap_addr1",  32'(u_if2.im_addr_o),     32'hFFFF);
    chk("wrap_pc1",    32'(u_if2.ifid_pc_o),     32'hFFFE);
    cycle(0, 0, 0);
    chk("wrap_addr2",  32'(u_if2.im_addr_o),     32'h0000);
    chk("wrap_pc2",    32'(u_if2.ifid_pc_o),     32'hFFFF);
    chk("wrap_inc2",   32'(u_if2.ifid_pc_inc_o), 32'h0000);
    cycle(0, 0, 0);
    chk("wrap_pc3",    32'(u_if2.ifid_pc_o),     32'h0000);
    cycle(0, 0, 0);
    chk("seq_instr",   32'(u_if.ifid_instr_o),   32'h1003);

    // Stall at pc=5.
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("stall_rd_en", 32'(u_if.im_rd_en_o),     32'h0);
    cycle(1, 0, 0);
    chk("stall_addr",  32'(u_if.im_addr_o),      32'h0005);
    cycle(0, 0, 0);
    chk("resume_addr", 32'(u_if.im_addr_o),      32'h0006);

    // Branch with simultaneous stall at pc=7.
    cycle(0, 0, 0);
    cycle(1, 1, 16'h0040);
    chk("br_addr",     32'(u_if.im_addr_o),      32'h0040);
    chk("br_valid",    32'(u_if.ifid_valid_o),   32'h0);
    cycle(0, 0, 0);
    chk("br_fetch",    32'(u_if.ifid_instr_o),   32'h1040);

    // Halt at address 9 with drain.
    mem[9] = 16'hF000;
    cycle(0, 1, 16'h0009);
    cycle(0, 0, 0);
    chk("hlt_capture", 32'(u_if.ifid_instr_o),   32'hF000);
    chk("hlt_pc",      32'(u_if.ifid_pc_o),      32'h0009);
    edges = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0);
      edges++;
      if (hlt_o) break;
    end
    chk("hlt_edges",   32'(edges),               32'd4);
    for (int k = 0; k < 3; k++) cycle(k[0], 1, 16'h0055);
    chk("hlt_sticky",  32'(hlt_o),               32'h1);
    chk("hlt_frozen",  32'(u_if.im_addr_o),      32'h0009);

    // Wrong-path halt cancelled by an older branch.
    do_reset();
    cycle(0, 1, 16'h0009);
    cycle(0, 0, 0);
    cycle(0, 1, 16'h0002);
    chk("cancel_addr", 32'(u_if.im_addr_o),      32'h0002);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0);
    chk("cancel_hlt",  32'(hlt_o),               32'h0);

    // Asynchronous reset during the drain.
    do_reset();
    cycle(0, 1, 16'h0009);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_addr",   32'(u_if.im_addr_o),      32'h0000);
    chk("arst_instr",  32'(u_if.ifid_instr_o),   32'h0000);
    chk("arst_pc",     32'(u_if.ifid_pc_o),      32'h0000);
    chk("arst_valid",  32'(u_if.ifid_valid_o),   32'h0);
    chk("arst_hlt",    32'(hlt_o),               32'h0);
    do_reset();

    // Randomised epochs over random memory contents.
    for (int ep = 0; ep < 6; ep++) begin
      int halted_for;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      do_reset();
      halted_for = 0;
      for (int n = 0; n < 300; n++) begin
        cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 16'($urandom));
        if (m_mode == 2) halted_for++;
        if (halted_for > 5) break;
      end
    end

    @(posedge clk); #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
